ahb_rr_arbiter: RTL and testbench
=================================

Name: ahb_rr_arbiter

Overview:
Parametrised AHB arbiter and master-side multiplexer for NUM_M bus masters. It succeeds the fixed two-master arbitration inside the current AHB block, adding:
- round-robin fairness;
- locked-transfer hold;
- a configurable burst-length cap that forces re-arbitration.

It sits between the master wrappers (CPU/I-cache/D-side/DMA) and the decoder/slave mux. It drives HGRANT back to each master and the shared address/control/write-data buses forward.

Parameters:
NUM_M, 4, number of masters (2..16)
AW, 32, address width
DW, 32, data width
MAX_BEATS, 16, consecutive non-IDLE beats an unlocked owner may issue before forced re-arbitration (0 = no cap)
MW, $clog2(NUM_M), HMASTER index width (derived; not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
HBUSREQ  in  NUM_M  per-master bus request
HLOCK  in  NUM_M  per-master lock request
HADDR_M  in  NUM_M*AW  packed master addresses; master i occupies bits [i*AW +: AW]
HTRANS_M  in  2*NUM_M  packed HTRANS
HWRITE_M  in  NUM_M  per-master HWRITE
HSIZE_M  in  3*NUM_M  packed HSIZE
HWDATA_M  in  NUM_M*DW  packed write data
HREADY  in  1  shared ready from slave mux
HGRANT  out  NUM_M  one-hot grant
HADDR  out  AW  muxed address
HTRANS  out  2  muxed transfer type
HWRITE  out  1  muxed write
HSIZE  out  3  muxed size
HWDATA  out  DW  muxed write data (data-phase owner)
HMASTER  out  MW  address-phase owner index
HMASTLOCK  out  1  address-phase lock

Behaviour:
- Reset values: grant_q=one-hot master 0, addr_owner=0, data_owner=0, lock_q=0, beat_cnt=0, last_idx=NUM_M-1. Outputs therefore reset to HGRANT=1, HMASTER=0, HMASTLOCK=0. HTRANS etc. follow master 0 combinationally. Reset mid-transfer aborts immediately.
- HGRANT = grant_q (registered).
- On clk edge with HREADY=1:
  - addr_owner <= idx(grant_q);
  - data_owner <= addr_owner;
  - lock_q <= HLOCK[idx(grant_q)].
- HREADY=0 freezes all state (grant_q, owners, beat_cnt).
- HADDR/HTRANS/HWRITE/HSIZE = combinational mux by addr_owner. HMASTER = addr_owner. HMASTLOCK = lock_q.
- HWDATA = HWDATA_M slice selected by data_owner. Write data therefore lags the address by exactly one HREADY-qualified cycle.
- beat_cnt, evaluated on HREADY=1 edges:
  - HTRANS (owner) = IDLE: cleared to 0.
  - Ownership changes: cleared to 0.
  - Otherwise: incremented, saturating at MAX_BEATS.
- Hold condition (grant unchanged), evaluated each HREADY=1 edge:
  - HLOCK[idx(grant_q)]=1 with HBUSREQ set, or lock_q=1 (the locked sequence plus one trailing cycle); or
  - owner HTRANS is SEQ or BUSY, and not (MAX_BEATS!=0 and beat_cnt==MAX_BEATS-1 and another master requests).
- Arbitration, when not holding:
  - Scan masters last_idx+1 .. last_idx+NUM_M modulo NUM_M. The first with HBUSREQ=1 wins. grant_q <= that master; last_idx <= winner.
  - No requests: park on master 0; last_idx unchanged.
  - Sole requester that is already the current owner keeps the grant, with no gap cycle.
- Forced re-arbitration mid-burst is legal AHB early termination. The pre-empted master restarts with NONSEQ; the arbiter does not track this.
- Simultaneous requests are resolved purely by round-robin order; there are no fixed priorities.
- HLOCK overrides the burst cap: a locked owner is never pre-empted.

Test Plan:
1. Reset with rst pulsed mid-cycle (async) while master 2 is owner -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0 immediately, without waiting for a clk edge.
2. Masters 1 and 3 request continuously, single NONSEQ transfers, HREADY=1 -> grants alternate 1,3,1,3. HMASTER follows one cycle later. HWDATA selects master 1's data two cycles after its grant.
3. Master 2 raises HLOCK+HBUSREQ with a 4-beat INCR burst while master 0 requests -> HGRANT stays 4'b0100 for the whole burst plus one cycle. HMASTLOCK=1 throughout the locked address phases. Master 0 is granted afterwards.
4. MAX_BEATS=4; master 1 issues an unlocked INCR of 8 beats while master 2 requests -> grant moves to master 2 after the 4th beat. beat_cnt resets to 0.
5. HREADY held 0 for 3 cycles during a grant change -> HGRANT, HMASTER and HWDATA source all hold their values. The change completes on the first HREADY=1 edge.
6. All HBUSREQ=0 after master 3 finishes -> park: HGRANT=4'b0001. A subsequent request from master 3 alone is granted, since the round-robin scan starts from last_idx+1 and reaches 3.

Source files
------------

// File: rtl/ahb_rr_arbiter_if.sv
// Bus bundle between the AHB master wrappers and the round-robin arbiter/master mux.
// Packed per-master fields: master i occupies slice i of each *_M vector.
interface ahb_rr_arbiter_if #(
    parameter int NUM_M = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int MW = $clog2(NUM_M);

    logic [NUM_M-1:0]    HBUSREQ;
    logic [NUM_M-1:0]    HLOCK;
    logic [NUM_M*AW-1:0] HADDR_M;
    logic [2*NUM_M-1:0]  HTRANS_M;
    logic [NUM_M-1:0]    HWRITE_M;
    logic [3*NUM_M-1:0]  HSIZE_M;
    logic [NUM_M*DW-1:0] HWDATA_M;
    logic                HREADY;

    logic [NUM_M-1:0]    HGRANT;
    logic [AW-1:0]       HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [DW-1:0]       HWDATA;
    logic [MW-1:0]       HMASTER;
    logic                HMASTLOCK;

    modport slave (
        input  HBUSREQ, HLOCK, HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HWDATA_M, HREADY,
        output HGRANT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER, HMASTLOCK
    );

    modport master (
        output HBUSREQ, HLOCK, HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HWDATA_M, HREADY,
        input  HGRANT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter and master-side mux with locked-transfer hold and a
// burst-length cap that forces re-arbitration of unlocked owners.
module ahb_rr_arbiter #(
    parameter int NUM_M     = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BEATS = 16
) (
    input logic             clk,
    input logic             rst,
    ahb_rr_arbiter_if.slave bus
);
    localparam int MW = $clog2(NUM_M);
    localparam int BW = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BEATS);
    localparam logic [BW-1:0] CAP_M1   = BW'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    // Handshake: HREADY is the single qualifier. Every register advances only on
    // a clk edge with HREADY=1; with HREADY=0 grant, owners, lock and beat count hold.

    logic [NUM_M-1:0] grant_q;
    logic [MW-1:0]    addr_owner;
    logic [MW-1:0]    data_owner;
    logic [MW-1:0]    last_idx;
    logic             lock_q;
    logic [BW-1:0]    beat_cnt;

    logic [AW-1:0]    haddr;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [2:0]       hsize;
    logic [DW-1:0]    hwdata;
    logic             own_lock;
    logic             own_req;
    logic [MW-1:0]    own_idx;

    logic [MW:0]      cand;
    logic [MW-1:0]    winner;
    logic             found;
    logic             other_req;
    logic             burst;
    logic             cap_hit;
    logic             hold;

    always_comb begin
        haddr    = '0;
        htrans   = HT_IDLE;
        hwrite   = 1'b0;
        hsize    = '0;
        hwdata   = '0;
        own_lock = 1'b0;
        own_req  = 1'b0;
        own_idx  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (addr_owner == MW'(i)) begin
                haddr  = bus.HADDR_M[i*AW +: AW];
                htrans = bus.HTRANS_M[2*i +: 2];
                hwrite = bus.HWRITE_M[i];
                hsize  = bus.HSIZE_M[3*i +: 3];
            end
            if (data_owner == MW'(i)) hwdata = bus.HWDATA_M[i*DW +: DW];
            if (grant_q[i]) begin
                own_lock = bus.HLOCK[i];
                own_req  = bus.HBUSREQ[i];
                own_idx  = MW'(i);
            end
        end
    end

    // Scan last_idx+1 .. last_idx+NUM_M (mod NUM_M); first requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = {1'b0, last_idx} + (MW+1)'(k);
            if (cand >= (MW+1)'(NUM_M)) cand = cand - (MW+1)'(NUM_M);
            if (!found && bus.HBUSREQ[cand[MW-1:0]]) begin
                found  = 1'b1;
                winner = cand[MW-1:0];
            end
        end
    end

    assign other_req = |(bus.HBUSREQ & ~grant_q);
    assign burst     = (htrans == HT_SEQ) || (htrans == HT_BUSY);
    assign cap_hit   = (MAX_BEATS != 0) && (beat_cnt == CAP_M1) && other_req;
    // Lock wins over the cap; lock_q keeps the grant one cycle past the locked sequence.
    assign hold      = (own_lock && own_req) || lock_q || (burst && !cap_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= NUM_M'(1);
            addr_owner <= '0;
            data_owner <= '0;
            lock_q     <= 1'b0;
            beat_cnt   <= '0;
            last_idx   <= MW'(NUM_M - 1);
        end else if (bus.HREADY) begin
            addr_owner <= own_idx;
            data_owner <= addr_owner;
            lock_q     <= own_lock;
            if (htrans == HT_IDLE || own_idx != addr_owner) beat_cnt <= '0;
            else if (beat_cnt != BEAT_MAX)                   beat_cnt <= beat_cnt + BW'(1);
            if (!hold) begin
                if (found) begin
                    grant_q  <= NUM_M'(1) << winner;
                    last_idx <= winner;
                end else begin
                    grant_q  <= NUM_M'(1);
                end
            end
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HADDR     = haddr;
    assign bus.HTRANS    = htrans;
    assign bus.HWRITE    = hwrite;
    assign bus.HSIZE     = hsize;
    assign bus.HWDATA    = hwdata;
    assign bus.HMASTER   = addr_owner;
    assign bus.HMASTLOCK = lock_q;
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: four masters, burst cap of 4 beats,
// hand-computed grant/owner/data tables per scenario.
module tb_ahb_rr_arbiter;
  localparam int NM = 4;
  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  ahb_rr_arbiter_if #(.NUM_M(NM), .AW(32), .DW(32)) bus ();

  ahb_rr_arbiter #(.NUM_M(NM), .AW(32), .DW(32), .MAX_BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int m);
    return 32'hA000_0000 + 32'(m) * 32'h100;
  endfunction

  function automatic logic [31:0] data_of(input int m);
    return 32'hD000_0000 + 32'(m);
  endfunction

  // driver tasks
  task automatic set_trans(input int m, input logic [1:0] t);
    bus.HTRANS_M[2*m +: 2] = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS_M = '0;
    bus.HREADY  = 1'b1;
    for (int m = 0; m < NM; m++) begin
      bus.HADDR_M[32*m +: 32]  = addr_of(m);
      bus.HWDATA_M[32*m +: 32] = data_of(m);
      bus.HSIZE_M[3*m +: 3]    = 3'(m);
      bus.HWRITE_M[m]          = m[0];
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.HGRANT !== 4'b0001) begin n_fail++; $display("FAIL reset_grant got %b exp %b", bus.HGRANT, 4'b0001); end
    n_cmp++; if (bus.HMASTER !== 2'd0) begin n_fail++; $display("FAIL reset_hmaster got %0d exp 0", bus.HMASTER); end
    n_cmp++; if (bus.HMASTLOCK !== 1'b0) begin n_fail++; $display("FAIL reset_mastlock got %b exp 0", bus.HMASTLOCK); end
    n_cmp++; if (bus.HWDATA !== data_of(0)) begin n_fail++; $display("FAIL reset_hwdata got %h exp %h", bus.HWDATA, data_of(0)); end
    // make master 2 the locked owner, then reset asynchronously mid-cycle
    bus.HBUSREQ = 4'b0100;
    bus.HLOCK   = 4'b0100;
    tick();
    tick();
    n_cmp++; if (bus.HGRANT !== 4'b0100 || bus.HMASTER !== 2'd2 || bus.HMASTLOCK !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_owner got g=%b m=%0d l=%b exp g=0100 m=2 l=1", bus.HGRANT, bus.HMASTER, bus.HMASTLOCK);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.HGRANT !== 4'b0001) begin n_fail++; $display("FAIL async_reset_grant got %b exp 0001", bus.HGRANT); end
    n_cmp++; if (bus.HMASTER !== 2'd0) begin n_fail++; $display("FAIL async_reset_hmaster got %0d exp 0", bus.HMASTER); end
    n_cmp++; if (bus.HMASTLOCK !== 1'b0) begin n_fail++; $display("FAIL async_reset_mastlock got %b exp 0", bus.HMASTLOCK); end
    n_cmp++; if (bus.HADDR !== addr_of(0)) begin n_fail++; $display("FAIL async_reset_haddr got %h exp %h", bus.HADDR, addr_of(0)); end
  endtask

  task automatic test_round_robin();
    int eg[4] = '{1, 3, 1, 3};
    int em[4] = '{0, 1, 3, 1};
    int ed[4] = '{0, 0, 1, 3};
    do_reset();
    bus.HBUSREQ = 4'b1010;
    for (int m = 0; m < NM; m++) set_trans(m, NSEQ);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (bus.HGRANT !== 4'(1 << eg[k])) begin n_fail++; $display("FAIL rr_grant[%0d] got %b exp %b", k, bus.HGRANT, 4'(1 << eg[k])); end
      n_cmp++; if (bus.HMASTER !== 2'(em[k])) begin n_fail++; $display("FAIL rr_hmaster[%0d] got %0d exp %0d", k, bus.HMASTER, em[k]); end
      n_cmp++; if (bus.HADDR !== addr_of(em[k]) || bus.HSIZE !== 3'(em[k]) || bus.HWRITE !== em[k][0]) begin
        n_fail++; $display("FAIL rr_addr_ctrl[%0d] got a=%h s=%0d w=%b exp owner %0d", k, bus.HADDR, bus.HSIZE, bus.HWRITE, em[k]);
      end
      n_cmp++; if (bus.HWDATA !== data_of(ed[k])) begin n_fail++; $display("FAIL rr_hwdata[%0d] got %h exp %h", k, bus.HWDATA, data_of(ed[k])); end
    end
  endtask

  task automatic test_locked_burst();
    logic [3:0] req_t[7]  = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0001};
    logic [3:0] lock_t[7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [1:0] tr_t[7]   = '{IDLE, IDLE, NSEQ, SEQ, SEQ, SEQ, IDLE};
    logic [3:0] eg[7]     = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    logic       el[7]     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int         em[7]     = '{0, 2, 2, 2, 2, 2, 2};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      bus.HBUSREQ = req_t[k];
      bus.HLOCK   = lock_t[k];
      set_trans(2, tr_t[k]);
      tick();
      n_cmp++; if (bus.HGRANT !== eg[k]) begin n_fail++; $display("FAIL lock_grant[%0d] got %b exp %b", k, bus.HGRANT, eg[k]); end
      n_cmp++; if (bus.HMASTLOCK !== el[k]) begin n_fail++; $display("FAIL lock_mastlock[%0d] got %b exp %b", k, bus.HMASTLOCK, el[k]); end
      n_cmp++; if (bus.HMASTER !== 2'(em[k])) begin n_fail++; $display("FAIL lock_hmaster[%0d] got %0d exp %0d", k, bus.HMASTER, em[k]); end
    end
  endtask

  task automatic test_burst_cap();
    logic [3:0] req_t[8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    logic [1:0] tr_t[8]  = '{IDLE, IDLE, NSEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
    logic [3:0] eg[8]    = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0010};
    int         em[8]    = '{0, 1, 1, 1, 1, 1, 2, 2};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.HBUSREQ = req_t[k];
      set_trans(1, tr_t[k]);
      tick();
      n_cmp++; if (bus.HGRANT !== eg[k]) begin n_fail++; $display("FAIL cap_grant[%0d] got %b exp %b", k, bus.HGRANT, eg[k]); end
      n_cmp++; if (bus.HMASTER !== 2'(em[k])) begin n_fail++; $display("FAIL cap_hmaster[%0d] got %0d exp %0d", k, bus.HMASTER, em[k]); end
    end
  endtask

  task automatic test_hready_stall();
    logic rdy_t[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   eg[8]    = '{1, 3, 1, 1, 1, 1, 3, 1};
    int   em[8]    = '{0, 1, 3, 3, 3, 3, 1, 3};
    int   ed[8]    = '{0, 0, 1, 1, 1, 1, 3, 1};
    do_reset();
    bus.HBUSREQ = 4'b1010;
    for (int m = 0; m < NM; m++) set_trans(m, NSEQ);
    for (int k = 0; k < 8; k++) begin
      bus.HREADY = rdy_t[k];
      tick();
      n_cmp++; if (bus.HGRANT !== 4'(1 << eg[k])) begin n_fail++; $display("FAIL stall_grant[%0d] got %b exp %b", k, bus.HGRANT, 4'(1 << eg[k])); end
      n_cmp++; if (bus.HMASTER !== 2'(em[k])) begin n_fail++; $display("FAIL stall_hmaster[%0d] got %0d exp %0d", k, bus.HMASTER, em[k]); end
      n_cmp++; if (bus.HWDATA !== data_of(ed[k])) begin n_fail++; $display("FAIL stall_hwdata[%0d] got %h exp %h", k, bus.HWDATA, data_of(ed[k])); end
    end
    bus.HREADY = 1'b1;
  endtask

  task automatic test_park();
    logic [3:0] req_t[4] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000};
    logic [1:0] tr_t[4]  = '{IDLE, IDLE, NSEQ, IDLE};
    logic [3:0] eg[4]    = '{4'b1000, 4'b0001, 4'b0001, 4'b1000};
    int         em[4]    = '{0, 3, 0, 0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.HBUSREQ = req_t[k];
      set_trans(3, tr_t[k]);
      tick();
      n_cmp++; if (bus.HGRANT !== eg[k]) begin n_fail++; $display("FAIL park_grant[%0d] got %b exp %b", k, bus.HGRANT, eg[k]); end
      n_cmp++; if (bus.HMASTER !== 2'(em[k])) begin n_fail++; $display("FAIL park_hmaster[%0d] got %0d exp %0d", k, bus.HMASTER, em[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_locked_burst();
    test_burst_cap();
    test_hready_stall();
    test_park();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
